// File: rtl/vmm_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : vmm_sched_if
// Purpose  : Auxiliary read request/acknowledge bus into the screen scheduler.
// Revision : 1.0
// ============================================================================
interface vmm_sched_if #(
  parameter int AW = 13
);
  logic          rreq;
  logic [AW-1:0] raddr;
  logic          rack;
  logic [7:0]    rdata;

  modport master (
    output rreq,
    output raddr,
    input  rack,
    input  rdata
  );

  modport slave (
    input  rreq,
    input  raddr,
    output rack,
    output rdata
  );
endinterface
`default_nettype wire

// File: rtl/vmm_sched.sv
`default_nettype none
// ============================================================================
// Module   : vmm_sched
// Purpose  : Screen RAM port-2 scheduler: per-line bitmap/attribute fetch with
//            idle read slots lent to one auxiliary requester.
// Revision : 1.0
// ============================================================================
module vmm_sched #(
  parameter int AW = 13
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          lineStart,
  input  logic [7:0]    line,
  output logic          ce2,
  output logic [AW-1:0] a2,
  input  logic [7:0]    do2,
  output logic [7:0]    pixel,
  output logic [7:0]    attr,
  output logic          pv,
  output logic          busy,
  vmm_sched_if.slave    aux
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  localparam logic [7:0] c_num_lines = 8'd192;
  localparam logic [4:0] c_last_col  = 5'd31;
  localparam logic [2:0] c_attr_base = 3'b110;

  state_t        r_state;
  state_t        w_state_n;
  logic [4:0]    r_col;
  logic [4:0]    w_col_n;
  logic [1:0]    r_slot;
  logic [1:0]    w_slot_n;
  logic [7:0]    r_line;
  logic [7:0]    w_line_n;

  logic          w_restart;
  logic          w_aux_ok;
  logic          w_grant;
  logic          w_vid;
  logic [AW-1:0] w_vaddr;
  logic [AW-1:0] r_a2;

  logic          r_gnt1;
  logic          r_rack;
  logic [7:0]    r_rdata;
  logic [7:0]    r_bmp;
  logic [7:0]    r_pixel;
  logic [7:0]    r_attr;
  logic          r_pv;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_slot  <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_state_n;
      r_col   <= w_col_n;
      r_slot  <= w_slot_n;
      r_line  <= w_line_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_col_n   = r_col;
    w_slot_n  = r_slot;
    w_line_n  = r_line;
    w_vid     = 1'b0;
    w_grant   = 1'b0;
    w_vaddr   = '0;
    w_restart = lineStart && (line < c_num_lines);
    // One aux read in flight at a time: blocked from grant until rack has shown.
    w_aux_ok  = reset && aux.rreq && !r_gnt1 && !r_rack;

    case (r_state)
      IDLE: begin
        w_grant = w_aux_ok;
      end
      FETCH: begin
        w_slot_n = r_slot + 2'd1;
        case (r_slot)
          2'd0: begin
            w_vid   = 1'b1;
            w_vaddr = {r_line[7:6], r_line[2:0], r_line[5:3], r_col};
          end
          2'd1: begin
            w_vid   = 1'b1;
            w_vaddr = {c_attr_base, r_line[7:3], r_col};
          end
          2'd2: begin
            w_grant = w_aux_ok;
          end
          default: begin
            w_col_n = r_col + 5'd1;
            if (r_col == c_last_col) begin
              w_state_n = IDLE;
            end
          end
        endcase
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase

    if (w_restart) begin
      w_state_n = FETCH;
      w_col_n   = '0;
      w_slot_n  = '0;
      w_line_n  = line;
    end

    ce2 = w_vid | w_grant;
    a2  = w_grant ? aux.raddr : (w_vid ? w_vaddr : r_a2);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_a2    <= '0;
      r_gnt1  <= 1'b0;
      r_rack  <= 1'b0;
      r_rdata <= '0;
      r_bmp   <= '0;
      r_pixel <= '0;
      r_attr  <= '0;
      r_pv    <= 1'b0;
    end else begin
      if (ce2) begin
        r_a2 <= a2;
      end
      r_gnt1 <= w_grant;
      r_rack <= r_gnt1;
      if (r_gnt1) begin
        r_rdata <= do2;
      end
      if ((r_state == FETCH) && (r_slot == 2'd1)) begin
        r_bmp <= do2;
      end
      // A restart landing on slot 2 drops the partial column's strobe.
      r_pv <= 1'b0;
      if ((r_state == FETCH) && (r_slot == 2'd2) && !w_restart) begin
        r_pixel <= r_bmp;
        r_attr  <= do2;
        r_pv    <= 1'b1;
      end
    end
  end

  assign busy      = (r_state == FETCH);
  assign pixel     = r_pixel;
  assign attr      = r_attr;
  assign pv        = r_pv;
  assign aux.rack  = r_rack;
  assign aux.rdata = r_rdata;

endmodule
`default_nettype wire

// File: doc/vmm_sched.md
# vmm_sched

Video-memory port-2 scheduler for the 8 KiB dual-port screen RAM. Once per active display line it fetches the 32 bitmap/attribute byte pairs in Spectrum screen order through the RAM's registered read port and delivers them as pixel/attribute pairs. It also lends idle read slots to one auxiliary requester (snapshot/debug reader) through a req/ack handshake. It sits between the video timing generator and the screen RAM read port; CPU writes use the RAM's other port and are not involved.

## Interface

- AW, 13, screen RAM address width; address arithmetic below assumes 13.

- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- lineStart  in  1  one-cycle pulse requesting a line fetch.
- line  in  8  display line 0..191, sampled with lineStart.
- ce2  out  1  read enable to screen RAM port 2.
- a2  out  AW  read address to screen RAM port 2.
- do  in  8  screen RAM read data; valid the cycle after ce2.
- pixel  out  8  bitmap byte of the delivered pair.
- attr  out  8  attribute byte of the delivered pair.
- pv  out  1  one-cycle strobe: pixel/attr valid.
- busy  out  1  high while a line fetch is in progress.
- rreq  in  1  auxiliary read request, level, held until rack.
- raddr  in  AW  auxiliary read address, stable while rreq high.
- rack  out  1  one-cycle acknowledge; rdata valid.
- rdata  out  8  auxiliary read data.

## Operation

- States: IDLE, FETCH. Column counter col 0..31, slot counter 0..3 inside FETCH.
- lineStart with line<192: enter FETCH, col=0, slot=0 next cycle; line latched. line>=192: ignored.
- FETCH slot 0: ce2=1, a2 = bitmap address {line[7:6], line[2:0], line[5:3], col}.
- Slot 1: ce2=1, a2 = attribute address {3'b110, line[7:3], col} (0x1800 + row*32 + col); do carries bitmap, latched.
- Slot 2: do carries attribute, latched; pixel/attr updated, pv=1 in the following cycle. Slot 2 is also the aux grant slot (ce2=1, a2=raddr if granted, else ce2=0).
- Slot 3: no video access. After slot 3 of col 31: back to IDLE.
- IDLE: aux request granted in any cycle (ce2=1, a2=raddr); ce2=0 otherwise.
- Aux: grant in cycle t, do valid t+1, rack=1 and rdata registered in t+2. Only one grant outstanding; no new grant until rack has issued. rreq still high the cycle after rack is a new request.
- lineStart during FETCH (line<192): abort, restart col 0 next cycle with new line; pv of the aborted partial column suppressed. Outstanding aux grant still completes with rack.
- a2 holds its last value when ce2=0.

## Timing

- Reset: ce2=0, a2=0, pixel=0, attr=0, pv=0, busy=0, rack=0, rdata=0, state IDLE, no pending aux; in-flight aux discarded (no rack).
- With lineStart sampled at edge s-1, column k slot 0 is cycle s+4k; busy high cycles s..s+127.
- pv for column k in cycle s+4k+3; 32 pulses, last at s+127.
- Aux latency: 2 cycles grant-to-rack in both states; worst-case wait in FETCH 4 cycles to grant.
- Aux rreq in the same cycle FETCH begins: served in slot 2 of col 0 (no IDLE grant that cycle).

## Test plan

- Reset then lineStart, line=0, do modelled as RAM: a2 sequence 0x0000, 0x1800, …, col 31 0x001F, 0x181F; 32 pv pulses, 4 cycles apart; busy exactly 128 cycles.
- line=65: col 0 addresses 0x0900/0x1900, col 31 0x091F/0x191F; pixel/attr equal preloaded RAM bytes.
- Idle aux read raddr=0x1ABC, RAM=0x5A: ce2 one cycle with a2=0x1ABC, rack one cycle 2 cycles later, rdata=0x5A; rreq held high → second grant the cycle after rack.
- Aux during FETCH: grant only in slot 2, no video pv corrupted, rack 2 cycles after grant.
- lineStart line=10 at col 7 slot 1: no pv for col 7, restart at 0x0220/0x1820 (line 10 col 0), 32 pv after restart; line=200 pulse: ignored, busy stays low.
- reset asserted mid-fetch with pending aux: next cycle all outputs 0, busy=0, no rack issued.
